// File: rtl/ovl_width_pulse_sequencer.sv
// ovl_width_pulse_sequencer: programmed pulse-train driver and fire counter for one ovl_width checker (rev 1.0)
// Option OVL_SEQ_FIRE_ABORT_EN: the first counted fire in LEAD/HIGH/LOW skips straight to DRAIN.
`default_nettype none

module ovl_width_pulse_sequencer #(
  parameter int CNT_W     = 8,
  parameter int NPULSE_W  = 4,
  parameter int FCNT_W    = 8,
  parameter int LEAD_CKS  = 2,
  parameter int DRAIN_CKS = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [CNT_W-1:0]    hi_cks,
  input  logic [CNT_W-1:0]    lo_cks,
  input  logic [NPULSE_W-1:0] num_pulses,
  input  logic                expect_fire,
  input  logic [2:0]          fire_in,
  output logic                enable,
  output logic                test_expr,
  output logic                busy,
  output logic                done,
  output logic [FCNT_W-1:0]   fire_cnt,
  output logic                pass
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEAD  = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    phase_cnt;
  logic [CNT_W-1:0]    hi_len;
  logic [CNT_W-1:0]    lo_len;
  logic [NPULSE_W-1:0] pulses_left;
  logic                exp_fire;

  logic                fire_hit;
  logic                phase_last;
  logic                abort;
  logic [FCNT_W-1:0]   fire_cnt_nxt;
  logic                unused_fire;

  // Only bit0 (assertion failure) matters; the other fire bits are ignored.
  assign unused_fire  = &{1'b0, fire_in[2:1]};
  assign fire_hit     = enable & fire_in[0];
  assign fire_cnt_nxt = (fire_hit && !(&fire_cnt)) ? fire_cnt + FCNT_W'(1) : fire_cnt;
  assign phase_last   = (phase_cnt == CNT_W'(1));

`ifdef OVL_SEQ_FIRE_ABORT_EN
  assign abort = fire_hit;
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= S_IDLE;
      phase_cnt   <= '0;
      hi_len      <= '0;
      lo_len      <= '0;
      pulses_left <= '0;
      exp_fire    <= 1'b0;
      enable      <= 1'b0;
      test_expr   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fire_cnt    <= '0;
      pass        <= 1'b0;
    end else begin
      done     <= 1'b0;
      fire_cnt <= fire_cnt_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            hi_len      <= (hi_cks == '0) ? CNT_W'(1) : hi_cks;
            lo_len      <= (lo_cks == '0) ? CNT_W'(1) : lo_cks;
            pulses_left <= num_pulses;
            exp_fire    <= expect_fire;
            fire_cnt    <= '0;
            pass        <= 1'b0;
            phase_cnt   <= CNT_W'(LEAD_CKS);
            enable      <= 1'b1;
            test_expr   <= 1'b0;
            busy        <= 1'b1;
            state       <= S_LEAD;
          end
        end
        S_LEAD: begin
          if (abort || (phase_last && pulses_left == '0)) begin
            phase_cnt <= CNT_W'(DRAIN_CKS);
            test_expr <= 1'b0;
            state     <= S_DRAIN;
          end else if (phase_last) begin
            phase_cnt <= hi_len;
            test_expr <= 1'b1;
            state     <= S_HIGH;
          end else begin
            phase_cnt <= phase_cnt - CNT_W'(1);
          end
        end
        S_HIGH: begin
          if (abort) begin
            phase_cnt <= CNT_W'(DRAIN_CKS);
            test_expr <= 1'b0;
            state     <= S_DRAIN;
          end else if (phase_last) begin
            phase_cnt <= lo_len;
            test_expr <= 1'b0;
            state     <= S_LOW;
          end else begin
            phase_cnt <= phase_cnt - CNT_W'(1);
          end
        end
        S_LOW: begin
          if (!abort && phase_last && pulses_left > NPULSE_W'(1)) begin
            pulses_left <= pulses_left - NPULSE_W'(1);
            phase_cnt   <= hi_len;
            test_expr   <= 1'b1;
            state       <= S_HIGH;
          end else if (abort || phase_last) begin
            pulses_left <= '0;
            phase_cnt   <= CNT_W'(DRAIN_CKS);
            test_expr   <= 1'b0;
            state       <= S_DRAIN;
          end else begin
            phase_cnt <= phase_cnt - CNT_W'(1);
          end
        end
        S_DRAIN: begin
          if (phase_last) begin
            // Verdict includes a fire seen on this final drain edge.
            pass      <= ((fire_cnt_nxt != '0) == exp_fire);
            phase_cnt <= '0;
            enable    <= 1'b0;
            test_expr <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= S_DONE;
          end else begin
            phase_cnt <= phase_cnt - CNT_W'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          enable    <= 1'b0;
          test_expr <= 1'b0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
